// File: rtl/tiny16_io_pkg.sv
// Shared definitions for the tiny16 UART: register offsets, STAT/CTRL bit
// positions and the serialiser/deserialiser state encodings.
package tiny16_io_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_STAT = 2'd1;
    localparam logic [1:0] REG_CTRL = 2'd2;
    localparam logic [1:0] REG_DIV  = 2'd3;

    localparam int unsigned STAT_TX_FULL   = 0;
    localparam int unsigned STAT_TX_EMPTY  = 1;
    localparam int unsigned STAT_RX_NEMPTY = 2;
    localparam int unsigned STAT_OVR       = 3;
    localparam int unsigned STAT_FERR      = 4;

    localparam int unsigned CTRL_RX_IRQ = 0;
    localparam int unsigned CTRL_TX_IRQ = 1;
    localparam int unsigned CTRL_LOOP   = 2;

    localparam logic [15:0] DIV_MIN = 16'd16;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

endpackage

// File: rtl/tiny16_sync_fifo.sv
// Synchronous show-ahead FIFO with extra-MSB pointers; push when full and
// pop when empty are ignored, simultaneous push/pop both take effect.
module tiny16_sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 3
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  push,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  pop,
    output logic [WIDTH-1:0]      rdata,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    logic [WIDTH-1:0]  r_mem [2**DEPTH_BITS];
    logic [DEPTH_BITS:0] r_wptr;
    logic [DEPTH_BITS:0] r_rptr;
    logic w_push;
    logic w_pop;

    assign empty  = (r_wptr == r_rptr);
    assign full   = (r_wptr[DEPTH_BITS] != r_rptr[DEPTH_BITS]) &&
                    (r_wptr[DEPTH_BITS-1:0] == r_rptr[DEPTH_BITS-1:0]);
    assign count  = r_wptr - r_rptr;
    assign rdata  = r_mem[r_rptr[DEPTH_BITS-1:0]];
    assign w_push = push & ~full;
    assign w_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr[DEPTH_BITS-1:0]] <= wdata;
    end

endmodule

// File: rtl/tiny16_io_uart.sv
// tiny16 I/O-bus UART: 4 registers at BASE_ADDR, 8-deep TX/RX FIFOs, 8N1 framing.
// Build option TINY16_UART_LOOPBACK_EN enables CTRL[2] internal tx->rx loopback.
module tiny16_io_uart #(
    parameter logic [7:0]  BASE_ADDR = 8'h10,
    parameter logic [15:0] DIV_RESET = 16'd434,
    parameter int unsigned FIFO_BITS = 3
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic [7:0]  address,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    input  logic        mem_valid,
    input  logic        nwr,
    output logic        mem_ready,
    output logic        interrupt,
    output logic        tx,
    input  logic        rx
);
    import tiny16_io_pkg::*;

    logic        w_sel, w_wr, w_stall, w_fire;
    logic [1:0]  w_reg;
    logic [15:0] w_rd_val;
    logic [2:0]  w_ctrl_wr;
    logic        r_ready, r_ovr, r_ferr, r_irq;
    logic [15:0] r_rdata, r_div;
    logic [2:0]  r_ctrl;

    logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty, w_tx_line, w_tx_tick;
    logic [7:0]  w_tx_dout;
    logic [FIFO_BITS:0] w_tx_count;
    tx_state_t   r_tx_state, w_tx_next;
    logic [15:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    logic [7:0]  r_tx_shift;

    logic        w_rx_src, w_rx_bit, w_rx_fall, w_rx_tick;
    logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty, w_rx_ferr_set, w_rx_ovr_set;
    logic [7:0]  w_rx_dout;
    logic [FIFO_BITS:0] w_rx_count;
    rx_state_t   r_rx_state, w_rx_next;
    logic [2:0]  r_rx_sync;
    logic [15:0] r_rx_cnt;
    logic [2:0]  r_rx_bit;
    logic [7:0]  r_rx_shift;

    assign w_sel     = mem_valid & (address[7:2] == BASE_ADDR[7:2]);
    assign w_wr      = ~nwr;
    assign w_reg     = address[1:0];
    assign w_stall   = w_wr & (w_reg == REG_DATA) & w_tx_full;
    assign w_fire    = w_sel & ~r_ready & ~w_stall;
    assign w_tx_push = w_fire & w_wr & (w_reg == REG_DATA);
    assign w_rx_pop  = w_fire & ~w_wr & (w_reg == REG_DATA);

    assign rdata     = r_rdata;
    assign mem_ready = r_ready;
    assign interrupt = r_irq;

`ifdef TINY16_UART_LOOPBACK_EN
    assign w_ctrl_wr = wdata[2:0];
    assign w_rx_src  = r_ctrl[CTRL_LOOP] ? w_tx_line : rx;
    assign tx        = r_ctrl[CTRL_LOOP] | w_tx_line;
`else
    assign w_ctrl_wr = {1'b0, wdata[1:0]};
    assign w_rx_src  = rx;
    assign tx        = w_tx_line;
`endif

    always_comb begin
        w_rd_val = '0;
        case (w_reg)
            REG_DATA: w_rd_val = w_rx_empty ? '0 : {7'b0, 1'b1, w_rx_dout};
            REG_STAT: w_rd_val = {11'b0, r_ferr, r_ovr, |w_rx_count, w_tx_empty, w_tx_full};
            REG_CTRL: w_rd_val = {13'b0, r_ctrl};
            default:  w_rd_val = r_div;
        endcase
    end

    // rdata is zero outside the ready pulse so the bus can be OR-combined.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_ready <= 1'b0;
            r_rdata <= '0;
            r_ctrl  <= '0;
            r_div   <= DIV_RESET;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            r_ready <= w_fire;
            r_rdata <= (w_fire & ~w_wr) ? w_rd_val : '0;
            r_irq   <= (r_ctrl[CTRL_RX_IRQ] & |w_rx_count) |
                       (r_ctrl[CTRL_TX_IRQ] & (w_tx_count == '0) & (r_tx_state == TX_IDLE));
            if (w_fire && w_wr && w_reg == REG_CTRL) r_ctrl <= w_ctrl_wr;
            if (w_fire && w_wr && w_reg == REG_DIV)  r_div  <= (wdata < DIV_MIN) ? DIV_MIN : wdata;
            if (w_rx_ovr_set) r_ovr <= 1'b1;
            else if (w_fire && w_wr && w_reg == REG_STAT && wdata[STAT_OVR]) r_ovr <= 1'b0;
            if (w_rx_ferr_set) r_ferr <= 1'b1;
            else if (w_fire && w_wr && w_reg == REG_STAT && wdata[STAT_FERR]) r_ferr <= 1'b0;
        end
    end

    tiny16_sync_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_BITS)) u_tx_fifo (
        .clk(clk), .nreset(nreset), .push(w_tx_push), .wdata(wdata[7:0]), .pop(w_tx_pop),
        .rdata(w_tx_dout), .full(w_tx_full), .empty(w_tx_empty), .count(w_tx_count)
    );

    tiny16_sync_fifo #(.WIDTH(8), .DEPTH_BITS(FIFO_BITS)) u_rx_fifo (
        .clk(clk), .nreset(nreset), .push(w_rx_push), .wdata(r_rx_shift), .pop(w_rx_pop),
        .rdata(w_rx_dout), .full(w_rx_full), .empty(w_rx_empty), .count(w_rx_count)
    );

    // >= lets a divisor reduced mid-frame end the current bit immediately.
    assign w_tx_tick = (r_tx_cnt >= r_div - 16'd1);

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_line = 1'b1;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE: if (!w_tx_empty) begin
                w_tx_pop  = 1'b1;
                w_tx_next = TX_START;
            end
            TX_START: begin
                w_tx_line = 1'b0;
                if (w_tx_tick) w_tx_next = TX_DATA;
            end
            TX_DATA: begin
                w_tx_line = r_tx_shift[0];
                if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = TX_STOP;
            end
            default: if (w_tx_tick) w_tx_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= (r_tx_state == TX_IDLE || w_tx_tick) ? '0 : r_tx_cnt + 16'd1;
            if (w_tx_pop) begin
                r_tx_shift <= w_tx_dout;
                r_tx_bit   <= '0;
            end else if (r_tx_state == TX_DATA && w_tx_tick) begin
                r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                r_tx_bit   <= r_tx_bit + 3'd1;
            end
        end
    end

    assign w_rx_bit  = r_rx_sync[1];
    assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];
    assign w_rx_tick = (r_rx_state == RX_START) ? (r_rx_cnt >= {1'b0, r_div[15:1]} - 16'd1)
                                                : (r_rx_cnt >= r_div - 16'd1);

    always_comb begin
        w_rx_next     = r_rx_state;
        w_rx_push     = 1'b0;
        w_rx_ferr_set = 1'b0;
        w_rx_ovr_set  = 1'b0;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
            RX_START: if (w_rx_tick) w_rx_next = w_rx_bit ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
            default: if (w_rx_tick) begin
                w_rx_next = RX_IDLE;
                if (!w_rx_bit)      w_rx_ferr_set = 1'b1;
                else if (w_rx_full) w_rx_ovr_set  = 1'b1;
                else                w_rx_push     = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rx_state <= RX_IDLE;
            r_rx_sync  <= '1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            r_rx_sync  <= {r_rx_sync[1:0], w_rx_src};
            r_rx_cnt   <= (r_rx_state == RX_IDLE || w_rx_tick) ? '0 : r_rx_cnt + 16'd1;
            if (r_rx_state == RX_IDLE) begin
                r_rx_bit <= '0;
            end else if (r_rx_state == RX_DATA && w_rx_tick) begin
                r_rx_shift <= {w_rx_bit, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_tiny16_io_uart.sv
// Randomised self-checking bench for tiny16_io_uart against a queue-based
// model of the register map, FIFOs and 8N1 framing.
`timescale 1ns/1ps
module tb_tiny16_io_uart;

    logic        clk = 1'b0;
    logic        nreset = 1'b1;
    logic [7:0]  address = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic        mem_valid = 1'b0;
    logic        nwr = 1'b1;
    logic        mem_ready;
    logic        interrupt;
    logic        tx;
    logic        rx = 1'b1;

    int n_checks = 0;
    int n_pass   = 0;
    int bench_div = 434;
    int last_lat;
    int mon_err = 0;
    logic [7:0] tx_got[$];
    logic [7:0] tx_exp[$];
    logic [7:0] rx_model[$];
    bit m_ovr = 1'b0;
    bit m_ferr = 1'b0;

    always #5 clk = ~clk;

    tiny16_io_uart #(.BASE_ADDR(8'h10), .DIV_RESET(16'd434), .FIFO_BITS(3)) dut (
        .clk(clk), .nreset(nreset), .address(address), .wdata(wdata), .rdata(rdata),
        .mem_valid(mem_valid), .nwr(nwr), .mem_ready(mem_ready), .interrupt(interrupt),
        .tx(tx), .rx(rx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic bus(input logic [7:0] addr, input bit wr, input logic [15:0] d,
                       output logic [15:0] q);
        int lat;
        @(posedge clk); #1;
        address = addr; wdata = d; nwr = ~wr; mem_valid = 1'b1;
        lat = 0; q = '0;
        while (1) begin
            @(posedge clk); #1;
            lat++;
            if (mem_ready) begin q = rdata; break; end
            if (lat > 5000) begin
                n_checks++;
                $display("FAIL bus_timeout: addr 0x%0h saw no mem_ready in %0d cycles", addr, lat);
                break;
            end
        end
        last_lat = lat;
        mem_valid = 1'b0; nwr = 1'b1;
    endtask

    task automatic reg_wr(input logic [1:0] r, input logic [15:0] d);
        logic [15:0] q;
        bus({6'b000100, r}, 1'b1, d, q);
    endtask

    task automatic reg_rd(input logic [1:0] r, output logic [15:0] q);
        bus({6'b000100, r}, 1'b0, 16'h0000, q);
    endtask

    task automatic set_div(input logic [15:0] d);
        reg_wr(2'd3, d);
        bench_div = (d < 16) ? 16 : int'(d);
    endtask

    function automatic logic [15:0] stat_idle();
        return {11'b0, m_ferr, m_ovr, rx_model.size() != 0, 1'b1, 1'b0};
    endfunction

    task automatic read_data_check(input string tag);
        logic [15:0] q, want;
        if (rx_model.size() > 0) want = {8'h01, rx_model.pop_front()};
        else want = 16'h0000;
        reg_rd(2'd0, q);
        check_eq(tag, q, want);
    endtask

    task automatic send_rx(input logic [7:0] b, input bit stop_ok);
        logic [9:0] f;
        f = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx = f[i];
            repeat (bench_div) @(posedge clk);
            #1;
        end
        rx = 1'b1;
        repeat (bench_div) @(posedge clk);
        #1;
        if (!stop_ok) m_ferr = 1'b1;
        else if (rx_model.size() >= 8) m_ovr = 1'b1;
        else rx_model.push_back(b);
    endtask

    task automatic send_glitch();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2 * bench_div) @(posedge clk);
        #1;
    endtask

    task automatic tx_byte(input logic [7:0] b);
        tx_exp.push_back(b);
        reg_wr(2'd0, {8'h00, b});
    endtask

    task automatic wait_tx(input string tag);
        int n;
        n = tx_exp.size();
        for (int c = 0; c < (n + 1) * 12 * bench_div && tx_got.size() < n; c++) @(posedge clk);
        repeat (2 * bench_div) @(posedge clk);
        #1;
        check_eq({tag, "_count"}, tx_got.size(), n);
        while (tx_exp.size() > 0 && tx_got.size() > 0)
            check_eq({tag, "_byte"}, tx_got.pop_front(), tx_exp.pop_front());
        tx_exp.delete();
        tx_got.delete();
    endtask

    // Decodes frames on the tx pin by sampling at each bit centre.
    initial begin : tx_mon
        logic [7:0] b;
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) begin
                repeat (bench_div / 2 - 1) @(negedge clk);
                if (tx !== 1'b0) mon_err++;
                for (int i = 0; i < 8; i++) begin
                    repeat (bench_div) @(negedge clk);
                    b[i] = tx;
                end
                repeat (bench_div) @(negedge clk);
                if (tx !== 1'b1) mon_err++;
                tx_got.push_back(b);
            end
            prev = tx;
        end
    end

    initial begin : main
        logic [15:0] q;
        int seen;
        int n;
        #2 nreset = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        @(posedge clk); #1;

        check_eq("rst_rdata", rdata, 16'h0000);
        check_eq("rst_ready", mem_ready, 1'b0);
        check_eq("rst_irq", interrupt, 1'b0);
        check_eq("rst_tx", tx, 1'b1);
        reg_rd(2'd1, q);
        check_eq("rst_stat", q, 16'h0002);
        check_eq("read_latency", last_lat, 1);
        reg_rd(2'd3, q);
        check_eq("rst_div", q, 16'd434);
        reg_rd(2'd0, q);
        check_eq("rst_data_empty", q, 16'h0000);

        address = 8'h21; nwr = 1'b1; mem_valid = 1'b1; seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (mem_ready || rdata != 16'h0) seen++;
        end
        mem_valid = 1'b0;
        check_eq("unselected_quiet", seen, 0);

        set_div(16'd5);
        reg_rd(2'd3, q);
        check_eq("div_clamp", q, 16'd16);
        set_div(16'd16);

        tx_byte(8'hA5);
        wait_tx("tx_a5");
        reg_rd(2'd1, q);
        check_eq("tx_empty_after", q, stat_idle());

        for (int i = 0; i < 10; i++) begin
            tx_byte(8'($urandom));
            if (i < 9) check_eq("b2b_latency", last_lat, 1);
            else check_eq("b2b_10th_stalled", last_lat > 50, 1'b1);
            if (i == 8) begin
                reg_rd(2'd1, q);
                check_eq("stat_tx_full", q, 16'h0001);
            end
        end
        reg_rd(2'd1, q);
        check_eq("after_stall_latency", last_lat, 1);
        wait_tx("tx_b2b");

        send_rx(8'h3C, 1'b1);
        reg_rd(2'd1, q);
        check_eq("stat_rx_nempty", q, stat_idle());
        read_data_check("rx_3c");
        read_data_check("rx_empty_again");

        for (int i = 0; i < 9; i++) send_rx(8'($urandom), 1'b1);
        reg_rd(2'd1, q);
        check_eq("stat_ovr", q, stat_idle());
        for (int i = 0; i < 8; i++) read_data_check("ovr_retained");
        reg_wr(2'd1, 16'h0008); m_ovr = 1'b0;
        reg_rd(2'd1, q);
        check_eq("ovr_cleared", q, stat_idle());

        send_rx(8'h77, 1'b0);
        send_glitch();
        reg_rd(2'd1, q);
        check_eq("stat_ferr", q, stat_idle());
        read_data_check("ferr_dropped");
        reg_wr(2'd1, 16'h0010); m_ferr = 1'b0;
        reg_rd(2'd1, q);
        check_eq("ferr_cleared", q, stat_idle());

        reg_wr(2'd2, 16'h0002);
        repeat (2) @(posedge clk); #1;
        check_eq("irq_tx_idle", interrupt, 1'b1);
        tx_byte(8'($urandom));
        repeat (5) @(posedge clk); #1;
        check_eq("irq_tx_busy", interrupt, 1'b0);
        wait_tx("tx_irq");
        check_eq("irq_tx_done", interrupt, 1'b1);
        reg_wr(2'd2, 16'h0001);
        repeat (2) @(posedge clk); #1;
        check_eq("irq_rx_none", interrupt, 1'b0);
        send_rx(8'($urandom), 1'b1);
        check_eq("irq_rx_byte", interrupt, 1'b1);
        read_data_check("irq_rx_data");
        repeat (2) @(posedge clk); #1;
        check_eq("irq_rx_cleared", interrupt, 1'b0);

        reg_wr(2'd2, 16'hFFFF);
        reg_rd(2'd2, q);
`ifdef TINY16_UART_LOOPBACK_EN
        check_eq("ctrl_readback", q, 16'h0007);
        reg_wr(2'd2, 16'h0005);
        reg_wr(2'd0, 16'h005A);
        rx_model.push_back(8'h5A);
        for (int c = 0; c < 14 * bench_div && !interrupt; c++) @(posedge clk);
        #1;
        check_eq("lb_irq", interrupt, 1'b1);
        read_data_check("lb_data");
        check_eq("lb_tx_held", tx_got.size(), 0);
`else
        check_eq("ctrl_readback", q, 16'h0003);
`endif
        reg_wr(2'd2, 16'h0000);

        for (int it = 0; it < 12; it++) begin
            set_div(16'($urandom_range(16, 40)));
            tx_byte(8'($urandom));
            if ($urandom_range(0, 1) == 1) tx_byte(8'($urandom));
            wait_tx("rnd_tx");
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) send_rx(8'($urandom), $urandom_range(0, 5) != 0);
            if ($urandom_range(0, 2) == 0) send_glitch();
            reg_rd(2'd1, q);
            check_eq("rnd_stat", q, stat_idle());
            while (rx_model.size() > 0) read_data_check("rnd_rx");
            read_data_check("rnd_rx_drained");
            reg_wr(2'd1, 16'h0018); m_ferr = 1'b0; m_ovr = 1'b0;
        end

        check_eq("tx_framing", mon_err, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
